spi_frame_master: RTL and testbench

- Parallel-to-SPI master that drives the raybox-zero vector and register SPI slave inputs (csb/sclk/mosi) from a parallel payload.
- Replaces bit-banging over LA with a single handshake per frame. One instance drives the vec slave, another drives the reg slave.
- Sits directly upstream of the top-level `i_vec_*` and `i_reg_*` ports.
- SPI mode 0, MSB-first, one frame per accepted request.

---
 rtl/spi_frame_master.sv | 135 +++++++++++++
 tb/tb_spi_frame_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// Parallel-to-SPI frame master, mode 0, MSB-first.
// One accepted request sends one frame of 1..DATA_W bits.
module spi_frame_master #(
    parameter int DATA_W = 80,
    parameter int LEN_W  = 7,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              csb_q, csb_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              last;
    logic [LEN_W-1:0]  bit_idx;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sreg_d  = sreg_q;
        done_d  = 1'b0;
        last    = (cnt_q == CNT_END);
        cnt_d   = last ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_start && i_len != '0) begin
                    state_d = S_SETUP;
                    sreg_d  = i_data;
                    rem_d   = (i_len > LEN_MAX) ? LEN_MAX : i_len;
                end
            end
            S_SETUP: if (last) state_d = S_HIGH;
            S_HIGH: begin
                // Count drops at the end of each high phase; 1 means last bit.
                if (last) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_HOLD : S_LOW;
                end
            end
            S_LOW:  if (last) state_d = S_HIGH;
            S_HOLD: if (last) state_d = S_GAP;
            S_GAP: begin
                if (last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they never glitch.
        bit_idx = rem_d - LEN_W'(1);
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        unique case (state_d)
            S_SETUP: begin
                csb_d  = 1'b0;
                mosi_d = sreg_d[bit_idx];
            end
            S_HIGH: begin
                csb_d  = 1'b0;
                sclk_d = 1'b1;
                mosi_d = mosi_q;
            end
            S_LOW: begin
                csb_d  = 1'b0;
                mosi_d = sreg_d[bit_idx];
            end
            S_HOLD: begin
                csb_d  = 1'b0;
                mosi_d = mosi_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sreg_q  <= '0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sreg_q  <= sreg_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_done  = done_q;
    assign o_csb   = csb_q;
    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: mode-0 slave model plus frame-level
// reference for bit order, edge count and busy time.
module tb_spi_frame_master;

    localparam int DATA_W = 80;
    localparam int LEN_W  = 7;
    localparam int DIV    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_start;
    logic [DATA_W-1:0] i_data;
    logic [LEN_W-1:0]  i_len;
    logic              o_ready, o_done, o_csb, o_sclk, o_mosi;

    int n_err = 0;
    int n_chk = 0;

    int edge_cnt, busy_cnt, done_cnt, done_bad, csb_low, gap_cyc, mosi_bad;
    logic [127:0] cap;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;

    spi_frame_master #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .DIV   (DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_data (i_data),
        .i_len  (i_len),
        .o_ready(o_ready),
        .o_done (o_done),
        .o_csb  (o_csb),
        .o_sclk (o_sclk),
        .o_mosi (o_mosi)
    );

    always #5 clk = ~clk;

    // Slave/bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_sclk && !prev_sclk && !o_csb) begin
            edge_cnt++;
            cap = {cap[126:0], o_mosi};
            if (o_mosi !== prev_mosi) mosi_bad++;
        end
        if (!o_ready) busy_cnt++;
        if (o_done) begin
            done_cnt++;
            if (!o_ready) done_bad++;
        end
        if (!o_csb) csb_low++;
        if (o_csb && !o_ready) gap_cyc++;
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        edge_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_bad = 0;
        csb_low  = 0;
        gap_cyc  = 0;
        mosi_bad = 0;
        cap      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    task automatic frame(input string tag, input logic [DATA_W-1:0] data,
                         input int len, input bit poke);
        int el;
        int budget;
        logic [127:0] exp;
        el  = (len > DATA_W) ? DATA_W : len;
        exp = '0;
        for (int b = el - 1; b >= 0; b--) exp = {exp[126:0], data[b]};
        budget = DIV * (2 * el + 2) + 20;
        clear_mon();
        i_data  = data;
        i_len   = LEN_W'(len);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_data  = rand_data();
        i_len   = LEN_W'($urandom_range(1, 127));
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            if (poke) i_start = (c == 5);
            tick();
        end
        i_start = 1'b0;
        repeat (3) tick();
        check({tag, "_edges"}, 128'(edge_cnt), 128'(el));
        check({tag, "_data"}, cap, exp);
        check({tag, "_busy"}, 128'(busy_cnt), 128'(DIV * (2 * el + 2)));
        check({tag, "_done"}, 128'(done_cnt), 128'd1);
        check({tag, "_done_ready"}, 128'(done_bad), 128'd0);
        check({tag, "_mosi_stable"}, 128'(mosi_bad), 128'd0);
        check({tag, "_gap"}, 128'(gap_cyc), 128'(DIV));
    endtask

    initial begin
        reset_n = 1'b0;
        i_start = 1'b0;
        i_data  = '0;
        i_len   = '0;
        clear_mon();
        repeat (3) tick();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_pins", 128'({o_csb, o_sclk, o_mosi, o_ready, o_done}),
                  128'(5'b10010));
        end

        frame("a5", DATA_W'(8'hA5), 8, 1'b0);
        frame("full", 80'h0123456789ABCDEF0FED, 100, 1'b0);

        clear_mon();
        i_data  = rand_data();
        i_len   = '0;
        i_start = 1'b1;
        repeat (3) tick();
        i_start = 1'b0;
        repeat (10) tick();
        check("len0_csb", 128'(csb_low), 128'd0);
        check("len0_busy", 128'(busy_cnt), 128'd0);

        frame("poke", DATA_W'(12'h5C3), 12, 1'b1);

        // Back-to-back: start held high across the done cycle.
        begin
            int drop;
            drop = 0;
            clear_mon();
            i_data  = DATA_W'(4'h9);
            i_len   = LEN_W'(4);
            i_start = 1'b1;
            tick();
            i_data = DATA_W'(4'h6);
            for (int c = 0; c < 100 && done_cnt < 2; c++) begin
                if (drop == 1) i_start = 1'b0;
                if (o_done && drop == 0) drop = 1;
                tick();
            end
            i_start = 1'b0;
            repeat (3) tick();
            check("b2b_edges", 128'(edge_cnt), 128'd8);
            check("b2b_data", cap, 128'h96);
            check("b2b_done", 128'(done_cnt), 128'd2);
            check("b2b_busy", 128'(busy_cnt), 128'(2 * DIV * 10));
            check("b2b_gap", 128'(gap_cyc), 128'(2 * DIV));
        end

        // Reset after the third rising edge of a 16-bit frame.
        clear_mon();
        i_data  = DATA_W'(16'hBEEF);
        i_len   = LEN_W'(16);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 200 && edge_cnt < 3; c++) tick();
        check("rst_reached", 128'(edge_cnt), 128'd3);
        reset_n = 1'b0;
        tick();
        check("rst_pins", 128'({o_csb, o_sclk, o_mosi, o_ready, o_done}),
              128'(5'b10010));
        reset_n = 1'b1;
        repeat (8) tick();
        check("rst_no_done", 128'(done_cnt), 128'd0);
        check("rst_idle", 128'(o_csb && o_ready), 128'd1);
        frame("after_rst", DATA_W'(8'h3C), 8, 1'b0);

        for (int k = 0; k < 6; k++)
            frame("rand", rand_data(), int'($urandom_range(1, 100)), k[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
